// File: rtl/polar_dec_pkg.sv
// rtl/polar_dec_pkg.sv - shared word-width and saturation constants for the polar decoder datapath
package polar_dec_pkg;

  localparam int LLR_W = 9;

  // Two's-complement pattern whose magnitude does not fit in LLR_W-1 bits.
  localparam logic [LLR_W-1:0] LLR_MOST_NEG = {1'b1, {(LLR_W-1){1'b0}}};

  localparam logic [LLR_W-2:0] LLR_SAT_MAG = '1;

endpackage

// File: rtl/twos_to_sign_mag_if.sv
// rtl/twos_to_sign_mag_if.sv - sample in/out bundle for the converter stage
// Optional sat_o signal present when TWO_TO_SIGN_SAT_FLAG_EN is defined.
interface twos_to_sign_mag_if
  import polar_dec_pkg::*;
#(
  parameter int WIDTH = LLR_W
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic             out_valid;
  logic [WIDTH-1:0] out1;
`ifdef TWO_TO_SIGN_SAT_FLAG_EN
  logic             sat_o;

  modport master (output in_valid, in1, input out_valid, out1, sat_o);
  modport slave  (input in_valid, in1, output out_valid, out1, sat_o);
`else
  modport master (output in_valid, in1, input out_valid, out1);
  modport slave  (input in_valid, in1, output out_valid, out1);
`endif

endinterface

// File: rtl/two_to_sign_core.sv
// rtl/two_to_sign_core.sv - combinational two's-complement to sign-magnitude conversion
// Saturation flag output present when TWO_TO_SIGN_SAT_FLAG_EN is defined.
module two_to_sign_core
  import polar_dec_pkg::*;
#(
  parameter int WIDTH = LLR_W
) (
  input  logic [WIDTH-1:0] x_i,
`ifdef TWO_TO_SIGN_SAT_FLAG_EN
  output logic             sat_o,
`endif
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-2:0] mag_w;
  logic             is_min_w;

  // Low bits of ~x+1 depend only on the low bits of x, so the sign bit is dropped early.
  assign mag_w    = ~x_i[WIDTH-2:0] + (WIDTH-1)'(1);
  assign is_min_w = x_i[WIDTH-1] & ~(|x_i[WIDTH-2:0]);

  always_comb begin
    y_o = x_i;
    if (x_i[WIDTH-1]) begin
      y_o = is_min_w ? '1 : {1'b1, mag_w};
    end
  end

`ifdef TWO_TO_SIGN_SAT_FLAG_EN
  assign sat_o = is_min_w;
`endif

endmodule

// File: rtl/twos_to_sign_mag.sv
// rtl/twos_to_sign_mag.sv - registered two's-complement to sign-magnitude stage, 1-cycle latency
// Registered sat_o flag added when TWO_TO_SIGN_SAT_FLAG_EN is defined.
module twos_to_sign_mag
  import polar_dec_pkg::*;
#(
  parameter int WIDTH = LLR_W
) (
  input  logic              clk,
  input  logic              rst,
  twos_to_sign_mag_if.slave bus
);

  logic [WIDTH-1:0] conv_w;
  logic [WIDTH-1:0] out1_d,      out1_q;
  logic             out_valid_d, out_valid_q;

`ifdef TWO_TO_SIGN_SAT_FLAG_EN
  logic sat_w, sat_d, sat_q;

  two_to_sign_core #(.WIDTH(WIDTH)) u_core (
    .x_i   (bus.in1),
    .sat_o (sat_w),
    .y_o   (conv_w)
  );
`else
  two_to_sign_core #(.WIDTH(WIDTH)) u_core (
    .x_i (bus.in1),
    .y_o (conv_w)
  );
`endif

  // Result and flag only move on an accepted sample; otherwise they hold.
  always_comb begin
    out_valid_d = bus.in_valid;
    out1_d      = bus.in_valid ? conv_w : out1_q;
`ifdef TWO_TO_SIGN_SAT_FLAG_EN
    sat_d       = bus.in_valid ? sat_w : sat_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out1_q      <= '0;
`ifdef TWO_TO_SIGN_SAT_FLAG_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out1_q      <= out1_d;
`ifdef TWO_TO_SIGN_SAT_FLAG_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out1      = out1_q;
`ifdef TWO_TO_SIGN_SAT_FLAG_EN
  assign bus.sat_o     = sat_q;
`endif

endmodule

// File: tb/tb_twos_to_sign_mag.sv
// tb/tb_twos_to_sign_mag.sv - scoreboard bench for twos_to_sign_mag at WIDTH=9 and WIDTH=6
// Checks sat_o as well when TWO_TO_SIGN_SAT_FLAG_EN is defined.
module tb_twos_to_sign_mag;
  import polar_dec_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  twos_to_sign_mag_if #(.WIDTH(LLR_W)) bus9 ();
  twos_to_sign_mag_if #(.WIDTH(6))     bus6 ();

  twos_to_sign_mag #(.WIDTH(LLR_W)) dut9 (.clk(clk), .rst(rst), .bus(bus9));
  twos_to_sign_mag #(.WIDTH(6))     dut6 (.clk(clk), .rst(rst), .bus(bus6));

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {sat, value}.
  logic [9:0] q9[$];
  logic [6:0] q6[$];
  logic [9:0] held9 = '0;
  logic [6:0] held6 = '0;

  logic [8:0] dir_in  [7];
  logic [9:0] dir_exp [7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ref_conv(input int w, input logic [8:0] x);
    int   v, mag, maxmag, r;
    logic sat;
    maxmag = (1 << (w - 1)) - 1;
    v      = int'(x) & ((1 << w) - 1);
    if (v > maxmag) v = v - (1 << w);
    sat = 1'b0;
    if (v >= 0) begin
      r = v;
    end else begin
      mag = -v;
      if (mag > maxmag) begin
        mag = maxmag;
        sat = 1'b1;
      end
      r = (1 << (w - 1)) | mag;
    end
    return {sat, 9'(r)};
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [8:0] x, input logic [9:0] exp9);
    logic [9:0] e6;
    rst           = r;
    bus9.in_valid = v;
    bus9.in1      = x;
    bus6.in_valid = v;
    bus6.in1      = x[5:0];
    if (v && !r) begin
      q9.push_back(exp9);
      e6 = ref_conv(6, x);
      q6.push_back({e6[9], e6[5:0]});
    end
    @(posedge clk);
    #1;
    if (r) begin
      held9 = '0;
      held6 = '0;
    end
    check("valid9", 32'(bus9.out_valid), 32'(v & ~r));
    check("valid6", 32'(bus6.out_valid), 32'(v & ~r));
    if (bus9.out_valid) begin
      check("sb9_pending", 32'(q9.size() > 0), 32'd1);
      if (q9.size() > 0) held9 = q9.pop_front();
    end
    if (bus6.out_valid) begin
      check("sb6_pending", 32'(q6.size() > 0), 32'd1);
      if (q6.size() > 0) held6 = q6.pop_front();
    end
    check("out9", 32'(bus9.out1), 32'(held9[8:0]));
    check("out6", 32'(bus6.out1), 32'(held6[5:0]));
`ifdef TWO_TO_SIGN_SAT_FLAG_EN
    check("sat9", 32'(bus9.sat_o), 32'(held9[9]));
    check("sat6", 32'(bus6.sat_o), 32'(held6[6]));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    dir_in  = '{9'h06A, 9'h1E7, 9'h000, 9'h1FF, 9'h0FF, LLR_MOST_NEG, 9'h101};
    dir_exp = '{10'h06A, 10'h119, 10'h000, 10'h101, 10'h0FF, 10'h3FF, 10'h1FF};
    rst           = 1'b1;
    bus9.in_valid = 1'b0;
    bus9.in1      = '0;
    bus6.in_valid = 1'b0;
    bus6.in1      = '0;

    cycle(1'b1, 1'b1, 9'h0AB, 10'h000);
    cycle(1'b1, 1'b1, 9'h0AB, 10'h000);

    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, dir_in[i], dir_exp[i]);
      if (i == 2) begin
        cycle(1'b0, 1'b0, 9'h155, 10'h000);
        cycle(1'b0, 1'b0, 9'h0AA, 10'h000);
      end
    end

    cycle(1'b1, 1'b1, 9'h0AB, 10'h000);
    cycle(1'b0, 1'b0, 9'h1E7, 10'h000);

    for (int i = 0; i < 512; i++) begin
      cycle(1'b0, 1'b1, 9'(i), ref_conv(9, 9'(i)));
    end
    cycle(1'b0, 1'b0, 9'h000, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
